// File: rtl/prga_fifo_rr_merger_pkg.sv
// Shared helpers for the round-robin FIFO merger: width calculation and defaults.
`default_nettype none
package prga_fifo_rr_merger_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 2;

  // ceil(log2(n)), never less than 1 so single-value fields still get a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_ID_WIDTH = clog2_min1(DEF_NUM_CH);

endpackage
`default_nettype wire

// File: rtl/prga_rr_picker.sv
// Combinational wrap-around search: first requester strictly after base_i,
// ending at base_i itself.
`default_nettype none
module prga_rr_picker
  import prga_fifo_rr_merger_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ID_WIDTH = DEF_ID_WIDTH
) (
  input  logic [NUM_CH-1:0]   req_i,
  input  logic [ID_WIDTH-1:0] base_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] sel_o
);

  localparam int SW = clog2_min1(NUM_CH);

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    int idx;
    idx     = 0;
    found_o = 1'b0;
    sel_o   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = int'(base_i) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req_i[SW'(idx)]) begin
        found_o = 1'b1;
        sel_o   = ID_WIDTH'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prga_fifo_rr_merger.sv
// Merges NUM_CH lookahead FIFO read ports into one lookahead port with
// round-robin arbitration, burst lock and per-word source tagging.
`default_nettype none
module prga_fifo_rr_merger
  import prga_fifo_rr_merger_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            empty_i,
  output logic [NUM_CH-1:0]            rd_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] dout_i,
  input  logic [NUM_CH-1:0]            mask,
  output logic                         empty,
  input  logic                         rd,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [ID_WIDTH-1:0]          src,
  output logic [ID_WIDTH-1:0]          owner
);

  localparam int SW = clog2_min1(NUM_CH);
  localparam int BW = clog2_min1(MAX_BURST);
  localparam logic [ID_WIDTH-1:0] OWNER_RST  = ID_WIDTH'(NUM_CH - 1);
  localparam logic [BW-1:0]       BURST_LAST = BW'(MAX_BURST - 1);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  held_q, held_d;

  logic [NUM_CH-1:0]     eligible;
  logic                  found;
  logic [ID_WIDTH-1:0]   pick;
  logic                  stay;
  logic                  can_load;
  logic [ID_WIDTH-1:0]   sel;
  logic [DATA_WIDTH-1:0] load_data;

  assign eligible = ~empty_i & ~mask;

  prga_rr_picker #(
    .NUM_CH   (NUM_CH),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req_i   (eligible),
    .base_i  (owner_q),
    .found_o (found),
    .sel_o   (pick)
  );

  // The reset owner holds no grant yet, so the first pick rotates to channel 0.
  assign stay     = held_q & eligible[SW'(owner_q)] & (burst_q != BURST_LAST);
  assign sel      = stay ? owner_q : pick;
  assign can_load = rst & (~valid_q | rd) & found;

  always_comb begin
    rd_i      = '0;
    load_data = '0;
    if (can_load) rd_i[SW'(sel)] = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (SW'(k) == SW'(sel)) load_data = dout_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    owner_d = owner_q;
    burst_d = burst_q;
    held_d  = held_q;
    if (can_load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      id_d    = sel;
      held_d  = 1'b1;
      if (stay) begin
        burst_d = burst_q + BW'(1);
      end else begin
        owner_d = pick;
        burst_d = '0;
      end
    end else if (rd && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      owner_q <= OWNER_RST;
      burst_q <= '0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      held_q  <= held_d;
    end
  end

  assign empty = ~valid_q;
  assign dout  = data_q;
  assign src   = id_q;
  assign owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_prga_fifo_rr_merger.sv
// Randomized and directed bench for prga_fifo_rr_merger against a queue-based
// arbitration model driven by the bench's own input FIFO images.
`default_nettype none
module tb_prga_fifo_rr_merger;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int MB = 2;
  localparam int IW = 2;
  localparam int DEPTH = 64;

  logic             clk;
  logic             rst;
  logic [NC-1:0]    empty_i;
  logic [NC-1:0]    rd_i;
  logic [NC*DW-1:0] dout_i;
  logic [NC-1:0]    mask;
  logic             empty;
  logic             rd;
  logic [DW-1:0]    dout;
  logic [IW-1:0]    src;
  logic [IW-1:0]    owner;

  prga_fifo_rr_merger #(
    .NUM_CH     (NC),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .ID_WIDTH   (IW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .empty_i (empty_i),
    .rd_i    (rd_i),
    .dout_i  (dout_i),
    .mask    (mask),
    .empty   (empty),
    .rd      (rd),
    .dout    (dout),
    .src     (src),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [NC][DEPTH];
  int wp [NC];
  int rp [NC];

  bit          m_valid;
  logic [DW-1:0] m_data;
  int          m_id;
  int          m_owner;
  int          m_burst;
  bit          m_held;

  int cons [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int ch, input logic [DW-1:0] v);
    mem[ch][wp[ch] % DEPTH] = v;
    wp[ch]++;
  endtask

  function automatic int cnt(input int ch);
    return wp[ch] - rp[ch];
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < NC; k++) begin
      empty_i[k] = (cnt(k) == 0);
      dout_i[k*DW +: DW] = (cnt(k) == 0) ? '0 : mem[k][rp[k] % DEPTH];
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit r);
    bit [NC-1:0] elig;
    bit          can;
    bit          stay;
    bit          got;
    int          sel;
    logic [NC-1:0] exp_rd;
    rd = r;
    drive_inputs();
    #1;
    for (int k = 0; k < NC; k++) elig[k] = (cnt(k) > 0) && !mask[k];
    can  = (!m_valid || r) && (elig != '0);
    stay = m_held && elig[m_owner] && (m_burst < MB - 1);
    sel  = m_owner;
    got  = 1'b0;
    if (!stay) begin
      for (int j = 1; j <= NC; j++) begin
        if (!got && elig[(m_owner + j) % NC]) begin
          sel = (m_owner + j) % NC;
          got = 1'b1;
        end
      end
    end
    exp_rd = '0;
    if (can) exp_rd[sel] = 1'b1;
    chk("rd_i", 32'(rd_i), 32'(exp_rd));
    chk("empty", 32'(empty), 32'(!m_valid));
    chk("owner", 32'(owner), 32'(m_owner));
    if (m_valid) begin
      chk("dout", 32'(dout), 32'(m_data));
      chk("src", 32'(src), 32'(m_id));
      if (r) cons.push_back(int'(src));
    end
    @(posedge clk);
    if (can) begin
      m_data = mem[sel][rp[sel] % DEPTH];
      rp[sel]++;
      m_id    = sel;
      m_valid = 1'b1;
      m_held  = 1'b1;
      if (stay) begin
        m_burst++;
      end else begin
        m_owner = sel;
        m_burst = 0;
      end
    end else if (r && m_valid) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the immediate effect, releases later.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_owner", 32'(owner), 32'(NC - 1));
    chk("rst_rd_i", 32'(rd_i), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_src", 32'(src), 32'd0);
    for (int k = 0; k < NC; k++) begin
      wp[k] = 0;
      rp[k] = 0;
    end
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_owner = NC - 1;
    m_burst = 0;
    m_held  = 1'b0;
    drive_inputs();
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp2 [12];
    exp2 = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    rst  = 1'b1;
    rd   = 1'b0;
    mask = '0;
    for (int k = 0; k < NC; k++) begin
      wp[k] = 0;
      rp[k] = 0;
    end
    drive_inputs();
    @(negedge clk);
    do_reset();

    // Idle with every channel empty
    repeat (6) cycle(1'b1);

    // Full preload, continuous consumption: burst pairs then single drains
    for (int k = 0; k < NC; k++)
      for (int w = 0; w < 3; w++) push(k, DW'(k * 16 + w));
    cons.delete();
    repeat (14) cycle(1'b1);
    chk("t2_count", 32'(cons.size()), 32'd12);
    for (int i = 0; i < 12 && i < cons.size(); i++) chk("t2_src_seq", 32'(cons[i]), 32'(exp2[i]));

    // Single active channel rotates back onto itself
    for (int w = 0; w < 5; w++) push(2, DW'(8'hA0 + w));
    cons.delete();
    repeat (7) cycle(1'b1);
    chk("t3_count", 32'(cons.size()), 32'd5);

    // Stalled consumer: one fill, then hold; one pop refills on the same edge
    for (int w = 0; w < 3; w++) begin
      push(1, DW'(8'h10 + w));
      push(3, DW'(8'h30 + w));
    end
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    repeat (2) cycle(1'b0);
    repeat (8) cycle(1'b1);

    // Masked channel is skipped until the mask clears
    mask = 4'b0010;
    for (int w = 0; w < 2; w++) push(1, DW'(8'h50 + w));
    for (int w = 0; w < 4; w++) push(3, DW'(8'h70 + w));
    repeat (6) cycle(1'b1);
    mask = 4'b0000;
    repeat (5) cycle(1'b1);

    // Asynchronous reset mid-stream, then restart from channel 0
    for (int k = 0; k < NC; k++)
      for (int w = 0; w < 2; w++) push(k, DW'(8'hC0 + k * 4 + w));
    repeat (3) cycle(1'b1);
    do_reset();
    for (int k = 0; k < NC; k++) push(k, DW'(8'hE0 + k));
    repeat (6) cycle(1'b1);

    // Randomized traffic, consumer stalls and mask changes
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NC; k++)
        if (cnt(k) < 8 && $urandom_range(0, 2) == 0) push(k, DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 15) == 0) mask = NC'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) mask = '0;
      cycle($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
